// File: rtl/xwalk_pkg.sv
// Shared types and constants for the crosswalk scheduler: lamp codes, phase and
// pedestrian state encodings, default durations and the countdown digit helper.
package xwalk_pkg;

    localparam logic [1:0] LT_RED = 2'b00;
    localparam logic [1:0] LT_YEL = 2'b01;
    localparam logic [1:0] LT_GRN = 2'b10;

    localparam int DEF_GREEN_T  = 40;
    localparam int DEF_YELLOW_T = 4;
    localparam int DEF_ALLRED_T = 2;
    localparam int DEF_WALK_T   = 8;
    localparam int DEF_FLASH_T  = 16;

    localparam int TIMER_W = 6;

    typedef enum logic [2:0] {
        PH_NS_G,
        PH_NS_Y,
        PH_RED_A,
        PH_EW_G,
        PH_EW_Y,
        PH_RED_B
    } phase_t;

    typedef enum logic [1:0] {
        PED_DONT,
        PED_WALK,
        PED_FLASH
    } ped_t;

    // Remaining-seconds digit during the blinking hand: pairs of ticks per digit.
    function automatic logic [3:0] flash_digit(input int flash_t, input logic [TIMER_W-1:0] e);
        int v;
        v = (flash_t - int'(e) + 1) / 2;
        return 4'(v);
    endfunction

endpackage

// File: rtl/xwalk_ped_seq.sv
// Pedestrian walk / blinking-hand / solid-hand sequencer, started by a grant.
// Countdown digit outputs exist only when XWALK_COUNTDOWN_EN is defined.
module xwalk_ped_seq
    import xwalk_pkg::*;
#(
    parameter int WALK_T  = DEF_WALK_T,
    parameter int FLASH_T = DEF_FLASH_T
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    output logic       walk,
    output logic       hand,
    output logic       num_on,
    output logic [3:0] num
);

    ped_t               state_reg, state_next;
    logic [TIMER_W-1:0] cnt_reg, cnt_next;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            PED_DONT: begin
                if (start) begin
                    state_next = PED_WALK;
                    cnt_next   = '0;
                end
            end
            PED_WALK: begin
                if (tick) begin
                    if (cnt_reg == TIMER_W'(WALK_T - 1)) begin
                        state_next = PED_FLASH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            PED_FLASH: begin
                if (tick) begin
                    if (cnt_reg == TIMER_W'(FLASH_T - 1)) begin
                        state_next = PED_DONT;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = PED_DONT;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the phase lamps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= PED_DONT;
            cnt_reg   <= '0;
            walk      <= 1'b0;
            hand      <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            walk      <= (state_next == PED_WALK);
            hand      <= (state_next == PED_DONT) ||
                         ((state_next == PED_FLASH) && cnt_next[0]);
        end
    end

`ifdef XWALK_COUNTDOWN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_on <= 1'b0;
            num    <= '0;
        end else begin
            num_on <= (state_next == PED_FLASH);
            num    <= (state_next == PED_FLASH) ? flash_digit(FLASH_T, cnt_next) : 4'd0;
        end
    end
`else
    assign num_on = 1'b0;
    assign num    = 4'd0;
`endif

endmodule

// File: rtl/xwalk_sched.sv
// Two-direction intersection scheduler with request-driven pedestrian crossings.
// Optional countdown digit enabled by defining XWALK_COUNTDOWN_EN.
module xwalk_sched
    import xwalk_pkg::*;
#(
    parameter int GREEN_T  = DEF_GREEN_T,
    parameter int YELLOW_T = DEF_YELLOW_T,
    parameter int ALLRED_T = DEF_ALLRED_T,
    parameter int WALK_T   = DEF_WALK_T,
    parameter int FLASH_T  = DEF_FLASH_T
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       req_ns,
    input  logic       req_ew,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       hand_ns,
    output logic       hand_ew,
    output logic       ack_ns,
    output logic       ack_ew,
    output logic       num_on,
    output logic [3:0] num
);

    phase_t             phase_reg, phase_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic               pending_ns_reg, pending_ew_reg;
    logic               phase_end, grant_ns, grant_ew;
    logic               ped_walk, ped_hand;
    logic               ns_green, ew_green;

    function automatic logic [TIMER_W-1:0] last_tick(input phase_t p);
        logic [TIMER_W-1:0] r;
        case (p)
            PH_NS_G, PH_EW_G:   r = TIMER_W'(GREEN_T - 1);
            PH_NS_Y, PH_EW_Y:   r = TIMER_W'(YELLOW_T - 1);
            default:            r = TIMER_W'(ALLRED_T - 1);
        endcase
        return r;
    endfunction

    function automatic phase_t succ(input phase_t p);
        phase_t r;
        case (p)
            PH_NS_G:  r = PH_NS_Y;
            PH_NS_Y:  r = PH_RED_A;
            PH_RED_A: r = PH_EW_G;
            PH_EW_G:  r = PH_EW_Y;
            PH_EW_Y:  r = PH_RED_B;
            default:  r = PH_NS_G;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] lamp(input phase_t p, input phase_t g, input phase_t y);
        logic [1:0] r;
        if (p == g)      r = LT_GRN;
        else if (p == y) r = LT_YEL;
        else             r = LT_RED;
        return r;
    endfunction

    assign phase_end  = tick && (timer_reg == last_tick(phase_reg));
    assign phase_next = phase_end ? succ(phase_reg) : phase_reg;
    assign timer_next = phase_end ? '0 : (tick ? timer_reg + 1'b1 : timer_reg);

    // Requests are only honoured at the tick that enters the matching green.
    assign grant_ns = phase_end && (phase_reg == PH_RED_B) && (pending_ns_reg || req_ns);
    assign grant_ew = phase_end && (phase_reg == PH_RED_A) && (pending_ew_reg || req_ew);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_reg      <= PH_NS_G;
            timer_reg      <= '0;
            pending_ns_reg <= 1'b0;
            pending_ew_reg <= 1'b0;
            ack_ns         <= 1'b0;
            ack_ew         <= 1'b0;
            ns_light       <= LT_GRN;
            ew_light       <= LT_RED;
        end else begin
            phase_reg      <= phase_next;
            timer_reg      <= timer_next;
            pending_ns_reg <= grant_ns ? 1'b0 : (pending_ns_reg || req_ns);
            pending_ew_reg <= grant_ew ? 1'b0 : (pending_ew_reg || req_ew);
            ack_ns         <= grant_ns;
            ack_ew         <= grant_ew;
            ns_light       <= lamp(phase_next, PH_NS_G, PH_NS_Y);
            ew_light       <= lamp(phase_next, PH_EW_G, PH_EW_Y);
        end
    end

    xwalk_ped_seq #(
        .WALK_T  (WALK_T),
        .FLASH_T (FLASH_T)
    ) u_ped (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .start  (grant_ns || grant_ew),
        .walk   (ped_walk),
        .hand   (ped_hand),
        .num_on (num_on),
        .num    (num)
    );

    // The shared sequencer only drives the direction that currently has green.
    assign ns_green = (phase_reg == PH_NS_G);
    assign ew_green = (phase_reg == PH_EW_G);
    assign walk_ns  = ns_green && ped_walk;
    assign walk_ew  = ew_green && ped_walk;
    assign hand_ns  = ns_green ? ped_hand : 1'b1;
    assign hand_ew  = ew_green ? ped_hand : 1'b1;

endmodule

// File: tb/tb_xwalk_sched.sv
// Randomized and directed bench for xwalk_sched against a tick-position model.
// Countdown expectations follow XWALK_COUNTDOWN_EN the same way the design does.
module tb_xwalk_sched;

    localparam int GREEN_T  = 40;
    localparam int YELLOW_T = 4;
    localparam int ALLRED_T = 2;
    localparam int WALK_T   = 8;
    localparam int FLASH_T  = 16;
    localparam int NS_Y_AT  = GREEN_T;
    localparam int RED_A_AT = NS_Y_AT + YELLOW_T;
    localparam int EW_G_AT  = RED_A_AT + ALLRED_T;
    localparam int EW_Y_AT  = EW_G_AT + GREEN_T;
    localparam int RED_B_AT = EW_Y_AT + YELLOW_T;
    localparam int CYCLE_T  = RED_B_AT + ALLRED_T;

    logic       clk = 1'b0;
    logic       reset, tick, req_ns, req_ew;
    logic [1:0] ns_light, ew_light;
    logic       walk_ns, walk_ew, hand_ns, hand_ew, ack_ns, ack_ew, num_on;
    logic [3:0] num;

    xwalk_sched dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .req_ns   (req_ns),
        .req_ew   (req_ew),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk_ns  (walk_ns),
        .walk_ew  (walk_ew),
        .hand_ns  (hand_ns),
        .hand_ew  (hand_ew),
        .ack_ns   (ack_ns),
        .ack_ew   (ack_ew),
        .num_on   (num_on),
        .num      (num)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: position within the 92-tick cycle plus per-direction pending/served flags.
    int         pos;
    bit         pend_ns, pend_ew, served_ns, served_ew;
    logic [1:0] exp_ack;

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // Returns {walk, hand, num_on, num[3:0]} for a direction k ticks into its green.
    function automatic logic [6:0] ped_view(input bit active, input int k);
        int e;
        if (!active || k >= WALK_T + FLASH_T) return 7'b0100000;
        if (k < WALK_T) return 7'b1000000;
        e = k - WALK_T;
        return {1'b0, e[0], 1'b1, 4'((FLASH_T - e + 1) / 2)};
    endfunction

    task automatic check_all(input string tag);
        logic [6:0] pn, pe;
        logic [1:0] lns, lew;
        logic [4:0] nexp;
        pn = ped_view(served_ns && pos < NS_Y_AT, pos);
        pe = ped_view(served_ew && pos >= EW_G_AT && pos < EW_Y_AT, pos - EW_G_AT);
        if (pos < NS_Y_AT)       lns = 2'b10;
        else if (pos < RED_A_AT) lns = 2'b01;
        else                     lns = 2'b00;
        if (pos >= EW_G_AT && pos < EW_Y_AT)       lew = 2'b10;
        else if (pos >= EW_Y_AT && pos < RED_B_AT) lew = 2'b01;
        else                                       lew = 2'b00;
        nexp = pn[4] ? pn[4:0] : pe[4:0];
`ifndef XWALK_COUNTDOWN_EN
        nexp = 5'd0;
`endif
        check_eq({tag, ":lights"}, int'({ns_light, ew_light}), int'({lns, lew}));
        check_eq({tag, ":peds"}, int'({walk_ns, hand_ns, walk_ew, hand_ew}),
                 int'({pn[6], pn[5], pe[6], pe[5]}));
        check_eq({tag, ":ack"}, int'({ack_ns, ack_ew}), int'(exp_ack));
        check_eq({tag, ":num"}, int'({num_on, num}), int'(nexp));
    endtask

    task automatic model_update(input bit t, input bit rn, input bit re);
        bit gn, ge;
        gn = 1'b0;
        ge = 1'b0;
        if (t) begin
            pos = (pos + 1) % CYCLE_T;
            if (pos == 0) begin
                gn = pend_ns || rn;
                served_ns = gn;
            end
            if (pos == EW_G_AT) begin
                ge = pend_ew || re;
                served_ew = ge;
            end
        end
        pend_ns = gn ? 1'b0 : (pend_ns || rn);
        pend_ew = ge ? 1'b0 : (pend_ew || re);
        exp_ack = {gn, ge};
        if (gn) $display("cycle %0d: ns crossing granted", cyc);
        if (ge) $display("cycle %0d: ew crossing granted", cyc);
    endtask

    task automatic step(input bit t, input bit rn, input bit re);
        tick   = t;
        req_ns = rn;
        req_ew = re;
        @(posedge clk);
        cyc++;
        model_update(t, rn, re);
        @(negedge clk);
        check_all("run");
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < 2 * CYCLE_T && pos != target; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    // Asserted away from the clock edge so the asynchronous clear is observed at once.
    task automatic apply_reset();
        tick   = 1'b0;
        req_ns = 1'b0;
        req_ew = 1'b0;
        reset  = 1'b0;
        #1;
        pos       = 0;
        pend_ns   = 1'b0;
        pend_ew   = 1'b0;
        served_ns = 1'b0;
        served_ew = 1'b0;
        exp_ack   = 2'b00;
        check_all("reset");
        @(posedge clk);
        @(negedge clk);
        check_all("reset_hold");
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        tick   = 1'b0;
        req_ns = 1'b0;
        req_ew = 1'b0;
        @(negedge clk);
        apply_reset();

        $display("free run");
        repeat (2 * CYCLE_T) step(1'b1, 1'b0, 1'b0);

        $display("basic grant, late request, coincident request");
        advance_to(EW_G_AT + 5);
        step(1'b1, 1'b1, 1'b0);
        advance_to(0);
        advance_to(3);
        step(1'b1, 1'b1, 1'b0);
        advance_to(RED_A_AT + ALLRED_T - 1);
        step(1'b1, 1'b0, 1'b1);
        advance_to(0);
        advance_to(30);

        $display("both pending then reset during flash");
        step(1'b1, 1'b1, 1'b1);
        advance_to(EW_G_AT + 1);
        advance_to(WALK_T + 3);
        step(1'b1, 1'b0, 1'b1);
        apply_reset();
        repeat (CYCLE_T + 10) step(1'b1, 1'b0, 1'b0);

        $display("tick stall during walk");
        step(1'b1, 1'b1, 1'b0);
        advance_to(0);
        advance_to(3);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, i == 7);
        advance_to(EW_G_AT + 2);
        advance_to(EW_Y_AT);

        $display("random traffic");
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                apply_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 30) == 0,
                     $urandom_range(0, 30) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
